// File: rtl/wb_pkg.sv
// Shared widths and write-port bundles for the writeback stage.
// No ports; imported by the interface, buffer slot and top.
package wb_pkg;
  localparam int DATA_W    = 32;
  localparam int VEC_LANES = 4;
  localparam int ADDR_W    = 5;
  localparam int VEC_W     = VEC_LANES * DATA_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } reg_wb_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [VEC_W-1:0]  data;
  } vec_wb_t;
endpackage

// File: rtl/writeback_controller_if.sv
// Bundle of scalar/vector pipe results, hazard controls and RF ports.
// master: drives pipe results and controls; slave: the writeback stage.
interface writeback_controller_if;
  import wb_pkg::*;

  logic              stall_mem;
  logic              s_reg_wr_en;
  logic              s_vec_wr_en;
  logic [ADDR_W-1:0] s_wr_addr;
  logic [DATA_W-1:0] s_reg_data;
  logic [VEC_W-1:0]  s_vec_data;
  logic              v_reg_wr_en;
  logic              v_vec_wr_en;
  logic [ADDR_W-1:0] v_wr_addr;
  logic [DATA_W-1:0] v_reg_data;
  logic [VEC_W-1:0]  v_vec_data;
  logic              register_wb_sel;
  logic              vector_wb_sel;
  logic              buffer_register;
  logic              buffer_vector;
  logic              buffer_register_sel;
  logic              buffer_vector_sel;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              vf_wr_en;
  logic [ADDR_W-1:0] vf_wr_addr;
  logic [VEC_W-1:0]  vf_wr_data;
  logic              reg_buf_valid;
  logic              vec_buf_valid;
  logic              wb_error;

  modport master (
    output stall_mem, s_reg_wr_en, s_vec_wr_en,
    output s_wr_addr, s_reg_data, s_vec_data,
    output v_reg_wr_en, v_vec_wr_en,
    output v_wr_addr, v_reg_data, v_vec_data,
    output register_wb_sel, vector_wb_sel,
    output buffer_register, buffer_vector,
    output buffer_register_sel, buffer_vector_sel,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    input  vf_wr_en, vf_wr_addr, vf_wr_data,
    input  reg_buf_valid, vec_buf_valid, wb_error
  );

  modport slave (
    input  stall_mem, s_reg_wr_en, s_vec_wr_en,
    input  s_wr_addr, s_reg_data, s_vec_data,
    input  v_reg_wr_en, v_vec_wr_en,
    input  v_wr_addr, v_reg_data, v_vec_data,
    input  register_wb_sel, vector_wb_sel,
    input  buffer_register, buffer_vector,
    input  buffer_register_sel, buffer_vector_sel,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    output vf_wr_en, vf_wr_addr, vf_wr_data,
    output reg_buf_valid, vec_buf_valid, wb_error
  );
endinterface

// File: rtl/wb_buffer_slot.sv
// One-entry side buffer for a deferred vector-pipe result.
// Ports: clk/rst, capture/drain controls, pipe_wr, entry in/out, err pulse.
// err is only computed when WB_PROTOCOL_CHECK_EN is defined.
module wb_buffer_slot
  import wb_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              drain,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [W-1:0]      in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      data,
  output logic              err
);

  // capture wins over drain so a same-cycle
  // drain+capture leaves the new entry held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef WB_PROTOCOL_CHECK_EN
  logic overflow;
  logic underflow;
  logic lost;

  assign overflow  = capture & valid & ~drain;
  assign underflow = drain & ~valid;
  // port busy draining while the pipe has
  // a result that is not being buffered
  assign lost      = drain & pipe_wr & ~capture;
  assign err       = overflow | underflow | lost;
`else
  logic unused_pipe_wr;
  assign unused_pipe_wr = pipe_wr;
  assign err            = 1'b0;
`endif

endmodule

// File: rtl/writeback_controller.sv
// Writeback stage: arbitrates scalar-RF and vector-RF write ports.
// Ports: clk, rst (async high), bus (writeback_controller_if.slave).
// Optional WB_PROTOCOL_CHECK_EN enables the sticky wb_error check.
module writeback_controller
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  writeback_controller_if.slave bus
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
  logic              v_valid;
  logic [ADDR_W-1:0] v_addr;
  logic [VEC_W-1:0]  v_data;
  logic              v_err;

  wb_buffer_slot #(.W(DATA_W)) u_reg_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (bus.buffer_register),
    .drain   (bus.buffer_register_sel),
    .pipe_wr (bus.v_reg_wr_en),
    .in_addr (bus.v_wr_addr),
    .in_data (bus.v_reg_data),
    .valid   (r_valid),
    .addr    (r_addr),
    .data    (r_data),
    .err     (r_err)
  );

  wb_buffer_slot #(.W(VEC_W)) u_vec_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (bus.buffer_vector),
    .drain   (bus.buffer_vector_sel),
    .pipe_wr (bus.v_vec_wr_en),
    .in_addr (bus.v_wr_addr),
    .in_data (bus.v_vec_data),
    .valid   (v_valid),
    .addr    (v_addr),
    .data    (v_data),
    .err     (v_err)
  );

  reg_wb_t rf;
  vec_wb_t vf;

  always_comb begin
    rf = '0;
    if (rst) begin
      rf.en = 1'b0;
    end else if (bus.buffer_register_sel) begin
      rf = '{1'b1, r_addr, r_data};
    end else if (bus.register_wb_sel) begin
      rf = '{1'b1, bus.v_wr_addr, bus.v_reg_data};
    end else if (bus.s_reg_wr_en & ~bus.stall_mem) begin
      rf = '{1'b1, bus.s_wr_addr, bus.s_reg_data};
    end
  end

  always_comb begin
    vf = '0;
    if (rst) begin
      vf.en = 1'b0;
    end else if (bus.buffer_vector_sel) begin
      vf = '{1'b1, v_addr, v_data};
    end else if (bus.vector_wb_sel) begin
      vf = '{1'b1, bus.v_wr_addr, bus.v_vec_data};
    end else if (bus.s_vec_wr_en & ~bus.stall_mem) begin
      vf = '{1'b1, bus.s_wr_addr, bus.s_vec_data};
    end
  end

  assign bus.rf_wr_en      = rf.en;
  assign bus.rf_wr_addr    = rf.addr;
  assign bus.rf_wr_data    = rf.data;
  assign bus.vf_wr_en      = vf.en;
  assign bus.vf_wr_addr    = vf.addr;
  assign bus.vf_wr_data    = vf.data;
  assign bus.reg_buf_valid = r_valid;
  assign bus.vec_buf_valid = v_valid;

`ifdef WB_PROTOCOL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (r_err | v_err) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (r_err || v_err)) begin
      $error("writeback buffer protocol error r=%0b v=%0b",
             r_err, v_err);
    end
  end

  assign bus.wb_error = err_q;
`else
  logic unused_err;
  assign unused_err   = r_err | v_err;
  assign bus.wb_error = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_controller.sv
// Randomized + directed scoreboard bench for writeback_controller.
// Stimulus pushes expected port values; a negedge monitor compares.
module tb_writeback_controller;
  import wb_pkg::*;

  logic clk;
  logic rst;

  writeback_controller_if bus();

  writeback_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         stall;
    logic         s_reg;
    logic         s_vec;
    logic [4:0]   s_addr;
    logic [31:0]  s_rd;
    logic [127:0] s_vd;
    logic         v_reg;
    logic         v_vec;
    logic [4:0]   v_addr;
    logic [31:0]  v_rd;
    logic [127:0] v_vd;
    logic         rsel;
    logic         vsel;
    logic         bufr;
    logic         bufv;
    logic         bufr_sel;
    logic         bufv_sel;
  } stim_t;

  typedef struct {
    logic         rf_en;
    logic [4:0]   rf_addr;
    logic [31:0]  rf_data;
    logic         vf_en;
    logic [4:0]   vf_addr;
    logic [127:0] vf_data;
    logic         rbv;
    logic         vbv;
    logic         err;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // reference model: contents of each side buffer and sticky error
  logic         mr_valid;
  logic [4:0]   mr_addr;
  logic [31:0]  mr_data;
  logic         mv_valid;
  logic [4:0]   mv_addr;
  logic [127:0] mv_data;
  logic         merr;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    logic perr;
    @(posedge clk);
    #1;
    rst                     = s.rst;
    bus.stall_mem           = s.stall;
    bus.s_reg_wr_en         = s.s_reg;
    bus.s_vec_wr_en         = s.s_vec;
    bus.s_wr_addr           = s.s_addr;
    bus.s_reg_data          = s.s_rd;
    bus.s_vec_data          = s.s_vd;
    bus.v_reg_wr_en         = s.v_reg;
    bus.v_vec_wr_en         = s.v_vec;
    bus.v_wr_addr           = s.v_addr;
    bus.v_reg_data          = s.v_rd;
    bus.v_vec_data          = s.v_vd;
    bus.register_wb_sel     = s.rsel;
    bus.vector_wb_sel       = s.vsel;
    bus.buffer_register     = s.bufr;
    bus.buffer_vector       = s.bufv;
    bus.buffer_register_sel = s.bufr_sel;
    bus.buffer_vector_sel   = s.bufv_sel;

    if (s.rst) begin
      mr_valid = 0; mr_addr = 0; mr_data = 0;
      mv_valid = 0; mv_addr = 0; mv_data = 0;
      merr = 0;
    end

    e = '{default: '0};
    if (!s.rst) begin
      if (s.bufr_sel) begin
        e.rf_en = 1; e.rf_addr = mr_addr; e.rf_data = mr_data;
      end else if (s.rsel) begin
        e.rf_en = 1; e.rf_addr = s.v_addr; e.rf_data = s.v_rd;
      end else if (s.s_reg && !s.stall) begin
        e.rf_en = 1; e.rf_addr = s.s_addr; e.rf_data = s.s_rd;
      end
      if (s.bufv_sel) begin
        e.vf_en = 1; e.vf_addr = mv_addr; e.vf_data = mv_data;
      end else if (s.vsel) begin
        e.vf_en = 1; e.vf_addr = s.v_addr; e.vf_data = s.v_vd;
      end else if (s.s_vec && !s.stall) begin
        e.vf_en = 1; e.vf_addr = s.s_addr; e.vf_data = s.s_vd;
      end
    end
    e.rbv = mr_valid;
    e.vbv = mv_valid;
    e.err = merr;
    q.push_back(e);

    if (!s.rst) begin
      perr = (s.bufr && mr_valid && !s.bufr_sel)
          || (s.bufr_sel && !mr_valid)
          || (s.bufr_sel && s.v_reg && !s.bufr)
          || (s.bufv && mv_valid && !s.bufv_sel)
          || (s.bufv_sel && !mv_valid)
          || (s.bufv_sel && s.v_vec && !s.bufv);
`ifdef WB_PROTOCOL_CHECK_EN
      if (perr) merr = 1;
`else
      if (perr) merr = merr;
`endif
      if (s.bufr) begin
        mr_valid = 1; mr_addr = s.v_addr; mr_data = s.v_rd;
      end else if (s.bufr_sel) begin
        mr_valid = 0;
      end
      if (s.bufv) begin
        mv_valid = 1; mv_addr = s.v_addr; mv_data = s.v_vd;
      end else if (s.bufv_sel) begin
        mv_valid = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rf_wr_en", bus.rf_wr_en, e.rf_en);
      if (e.rf_en) begin
        chk("rf_wr_addr", bus.rf_wr_addr, e.rf_addr);
        chk("rf_wr_data", bus.rf_wr_data, e.rf_data);
      end
      chk("vf_wr_en", bus.vf_wr_en, e.vf_en);
      if (e.vf_en) begin
        chk("vf_wr_addr", bus.vf_wr_addr, e.vf_addr);
        chk("vf_wr_data", bus.vf_wr_data, e.vf_data);
      end
      chk("reg_buf_valid", bus.reg_buf_valid, e.rbv);
      chk("vec_buf_valid", bus.vec_buf_valid, e.vbv);
      chk("wb_error", bus.wb_error, e.err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit hit, %0d pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [127:0] lanes;
    rst = 1'b1;
    s = idle();
    s.rst = 1;
    apply(s);
    apply(s);

    // reset mid-buffer
    s = idle();
    s.bufr = 1; s.v_reg = 1; s.v_addr = 5; s.v_rd = 32'hDEAD;
    apply(s);
    s = idle(); s.rst = 1; s.s_reg = 1; s.s_addr = 1;
    apply(s);
    s = idle();
    apply(s);
    apply(s);

    // scalar only, then stalled
    s = idle();
    s.s_reg = 1; s.s_addr = 3; s.s_rd = 32'h11;
    apply(s);
    s.stall = 1;
    apply(s);

    // deferred vector write
    s = idle();
    s.bufr = 1; s.v_reg = 1; s.v_addr = 7; s.v_rd = 32'hAA;
    s.s_reg = 1; s.s_addr = 7; s.s_rd = 32'hBB;
    apply(s);
    s = idle(); s.bufr_sel = 1;
    apply(s);
    s = idle();
    apply(s);

    // hold under stall
    lanes = {32'd4, 32'd3, 32'd2, 32'd1};
    s = idle();
    s.bufv = 1; s.v_vec = 1; s.v_addr = 2; s.v_vd = lanes;
    apply(s);
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.stall = 1; s.s_vec = 1; s.s_addr = 6;
      apply(s);
    end
    s = idle(); s.bufv_sel = 1;
    apply(s);

    // back-to-back drain + capture
    s = idle();
    s.bufr = 1; s.v_reg = 1; s.v_addr = 4; s.v_rd = 32'h1;
    apply(s);
    s = idle();
    s.bufr_sel = 1; s.bufr = 1; s.v_reg = 1;
    s.v_addr = 9; s.v_rd = 32'h2;
    apply(s);
    s = idle(); s.bufr_sel = 1;
    apply(s);
    s = idle();
    apply(s);

    // overflow, sticky, reset, then underflow
    s = idle();
    s.bufr = 1; s.v_reg = 1; s.v_addr = 1; s.v_rd = 32'h5;
    apply(s);
    s.v_rd = 32'h6;
    apply(s);
    s = idle();
    apply(s);
    apply(s);
    s.rst = 1;
    apply(s);
    s = idle();
    apply(s);
    s.bufv_sel = 1;
    apply(s);
    s = idle();
    apply(s);
    apply(s);
    s.rst = 1;
    apply(s);

    // randomized legal traffic
    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 96) == 0);
      s.stall  = ($urandom_range(0, 3) == 0);
      s.s_reg  = $urandom_range(0, 1);
      s.s_vec  = $urandom_range(0, 1);
      s.s_addr = $urandom_range(0, 31);
      s.s_rd   = $urandom;
      s.s_vd   = {$urandom, $urandom, $urandom, $urandom};
      s.v_addr = $urandom_range(0, 31);
      s.v_rd   = $urandom;
      s.v_vd   = {$urandom, $urandom, $urandom, $urandom};
      s.rsel   = ($urandom_range(0, 2) == 0);
      s.vsel   = ($urandom_range(0, 2) == 0);
      s.bufr_sel = mr_valid && ($urandom_range(0, 1) == 1);
      s.bufv_sel = mv_valid && ($urandom_range(0, 1) == 1);
      s.bufr = (!mr_valid || s.bufr_sel)
            && ($urandom_range(0, 2) == 0);
      s.bufv = (!mv_valid || s.bufv_sel)
            && ($urandom_range(0, 2) == 0);
      s.v_reg = s.bufr ? 1'b1 :
                s.bufr_sel ? 1'b0 : 1'($urandom_range(0, 1));
      s.v_vec = s.bufv ? 1'b1 :
                s.bufv_sel ? 1'b0 : 1'($urandom_range(0, 1));
      apply(s);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 128'(q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
